// File: rtl/fifo_dual_read_ctrl_pkg.sv
// fifo_ctrl_pkg: shared definitions for the dual-read FIFO controller.
//   - state_t        : frame FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - *_DEF          : default FIFO geometry and frame-length width
//   - STATS_W        : width of the optional stall counters (FIFO_CTRL_STATS_EN)
//   - sat_inc        : saturating increment for the stall counters
package fifo_ctrl_pkg;
   localparam int BUFFER_WIDTH_DEF = 4;
   localparam int BUFFER_SIZE_DEF  = 16;
   localparam int LEN_WIDTH_DEF    = 16;
   localparam int STATS_W          = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (&v) ? v : v + STATS_W'(1);
   endfunction
endpackage

// File: rtl/fifo_dual_read_ctrl_if.sv
// fifo_dual_read_ctrl_if: the three valid/ready streams around the controller.
//   in_valid/in_ready     : upstream producer -> FIFO
//   outp_valid/outp_ready : FIFO DataOut1 -> port P consumer
//   outm_valid/outm_ready : FIFO DataOut2 -> port M consumer
// master = controller side, slave = producer/consumer side.
interface fifo_dual_read_ctrl_if;
   logic in_valid;
   logic in_ready;
   logic outp_valid;
   logic outp_ready;
   logic outm_valid;
   logic outm_ready;

   modport master (
      input  in_valid, outp_ready, outm_ready,
      output in_ready, outp_valid, outm_valid
   );

   modport slave (
      output in_valid, outp_ready, outm_ready,
      input  in_ready, outp_valid, outm_valid
   );
endinterface

// File: rtl/fifo_dual_read_ctrl_occ_counter.sv
// occ_counter: W-bit up/down occupancy counter for one FIFO read pointer.
//   clk, aclr (async, active-low), clear (sync), inc (push), dec (pop), count.
// inc and dec together leave the count unchanged.
module occ_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         aclr,
   input  logic         clear,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr)              count <= '0;
      else if (clear)         count <= '0;
      else if (inc && !dec)   count <= count + W'(1);
      else if (dec && !inc)   count <= count - W'(1);
   end
endmodule

// File: rtl/fifo_dual_read_ctrl.sv
// fifo_dual_read_ctrl: frame controller for the dual-read-pointer FIFO.
// Generates Push/Pop1/Pop2 from one upstream and two downstream handshakes,
// keeps per-reader occupancy so no slot is overwritten before both readers
// consumed it, and sequences one cfg_len-word frame per start.
// Ports:
//   clk, aclr (async, active-low; shared with the FIFO)
//   start, cfg_len   : frame command, cfg_len sampled on accepted start
//   busy, done       : frame in progress / one-cycle completion pulse
//   hs (master)      : in/outp/outm valid-ready streams
//   Push, Pop1, Pop2 : FIFO strobes
//   stall_in_cnt, stall_p_cnt, stall_m_cnt : only with FIFO_CTRL_STATS_EN
module fifo_dual_read_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int BufferWidth = BUFFER_WIDTH_DEF,
   parameter int BufferSize  = BUFFER_SIZE_DEF,
   parameter int LenWidth    = LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  aclr,
   input  logic                  start,
   input  logic [LenWidth-1:0]   cfg_len,
   output logic                  busy,
   output logic                  done,
   fifo_dual_read_ctrl_if.master hs,
   output logic                  Push,
   output logic                  Pop1,
   output logic                  Pop2
`ifdef FIFO_CTRL_STATS_EN
   ,
   output logic [STATS_W-1:0]    stall_in_cnt,
   output logic [STATS_W-1:0]    stall_p_cnt,
   output logic [STATS_W-1:0]    stall_m_cnt
`endif
);
   localparam int            OW   = BufferWidth + 1;
   localparam logic [OW-1:0] FULL = OW'(BufferSize);

   state_t              state, state_nxt;
   logic [LenWidth-1:0] len_q, push_cnt, popp_cnt, popm_cnt;
   logic [LenWidth-1:0] push_nxt, popp_nxt, popm_nxt;
   logic [OW-1:0]       occ_p, occ_m, occ;
   logic                start_acc, active;
   logic                in_rdy, p_vld, m_vld;

   assign start_acc = start && (state == IDLE);
   assign active    = (state == RUN) || (state == DRAIN);
   // Slot reuse is gated by the slower reader.
   assign occ       = (occ_p > occ_m) ? occ_p : occ_m;
   // Post-edge counts let the FSM leave RUN/DRAIN on the same edge as the
   // final push/pop, so done lands exactly one cycle after the last pop.
   assign push_nxt  = push_cnt + LenWidth'(Push);
   assign popp_nxt  = popp_cnt + LenWidth'(Pop1);
   assign popm_nxt  = popm_cnt + LenWidth'(Pop2);

   // ---- FSM: state register
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---- FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (cfg_len != '0) ? RUN : DONE;
         RUN:     if (push_nxt == len_q) state_nxt = DRAIN;
         DRAIN:   if ((popp_nxt == len_q) && (popm_nxt == len_q)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- FSM: outputs. in_ready depends on registered state only, so no
   // combinational path exists from the downstream readys to it.
   always_comb begin
      in_rdy = (state == RUN) && (occ < FULL);
      p_vld  = active && (occ_p != '0) && (popp_cnt < len_q);
      m_vld  = active && (occ_m != '0) && (popm_cnt < len_q);
      busy   = active;
      done   = (state == DONE);
      Push   = hs.in_valid && in_rdy;
      Pop1   = p_vld && hs.outp_ready;
      Pop2   = m_vld && hs.outm_ready;
   end

   assign hs.in_ready   = in_rdy;
   assign hs.outp_valid = p_vld;
   assign hs.outm_valid = m_vld;

   // ---- frame counters
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         len_q    <= '0;
         push_cnt <= '0;
         popp_cnt <= '0;
         popm_cnt <= '0;
      end else if (start_acc) begin
         len_q    <= cfg_len;
         push_cnt <= '0;
         popp_cnt <= '0;
         popm_cnt <= '0;
      end else begin
         push_cnt <= push_nxt;
         popp_cnt <= popp_nxt;
         popm_cnt <= popm_nxt;
      end
   end

   // Occupancies are already zero between frames; the start clear only
   // re-anchors them in case a frame was abandoned by an upstream reset.
   occ_counter #(.W(OW)) u_occ_p (
      .clk(clk), .aclr(aclr), .clear(start_acc), .inc(Push), .dec(Pop1), .count(occ_p)
   );
   occ_counter #(.W(OW)) u_occ_m (
      .clk(clk), .aclr(aclr), .clear(start_acc), .inc(Push), .dec(Pop2), .count(occ_m)
   );

`ifdef FIFO_CTRL_STATS_EN
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         stall_in_cnt <= '0;
         stall_p_cnt  <= '0;
         stall_m_cnt  <= '0;
      end else if (start_acc) begin
         stall_in_cnt <= '0;
         stall_p_cnt  <= '0;
         stall_m_cnt  <= '0;
      end else begin
         if ((state == RUN) && hs.in_valid && !in_rdy) stall_in_cnt <= sat_inc(stall_in_cnt);
         if (p_vld && !hs.outp_ready)                   stall_p_cnt  <= sat_inc(stall_p_cnt);
         if (m_vld && !hs.outm_ready)                   stall_m_cnt  <= sat_inc(stall_m_cnt);
      end
   end
`endif
endmodule

// File: tb/tb_fifo_dual_read_ctrl.sv
// Testbench for fifo_dual_read_ctrl: table of frame vectors plus hand-written
// busy-start and mid-frame-reset sequences. A behavioural FIFO driven by the
// DUT strobes feeds a scoreboard of words accepted upstream.
module tb_fifo_dual_read_ctrl;
   import fifo_ctrl_pkg::*;
   localparam int BW = 4;
   localparam int BS = 16;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          aclr = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic          busy, done, Push, Pop1, Pop2;

   fifo_dual_read_ctrl_if hs ();

`ifdef FIFO_CTRL_STATS_EN
   logic [STATS_W-1:0] s_in, s_p, s_m;
`endif

   fifo_dual_read_ctrl #(.BufferWidth(BW), .BufferSize(BS), .LenWidth(LW)) dut (
      .clk(clk), .aclr(aclr), .start(start), .cfg_len(cfg_len),
      .busy(busy), .done(done), .hs(hs),
      .Push(Push), .Pop1(Pop1), .Pop2(Pop2)
`ifdef FIFO_CTRL_STATS_EN
      , .stall_in_cnt(s_in), .stall_p_cnt(s_p), .stall_m_cnt(s_m)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int pushes, pops_p, pops_m, dones;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // ---- behavioural FIFO + scoreboard
   logic [15:0]   mem [BS];
   logic [BW-1:0] wp = '0, rp1 = '0, rp2 = '0;
   logic [15:0]   din = 16'h100;
   int            exp_p[$], exp_m[$];

   always @(negedge clk) begin
      if (!aclr) begin
         wp = '0; rp1 = '0; rp2 = '0;
         exp_p.delete(); exp_m.delete();
      end else begin
         if (Pop1) begin
            pops_p++;
            if (exp_p.size() == 0) chk("p_underflow", 1, 0);
            else chk("p_data", int'(mem[rp1]), exp_p.pop_front());
            rp1++;
         end
         if (Pop2) begin
            pops_m++;
            if (exp_m.size() == 0) chk("m_underflow", 1, 0);
            else chk("m_data", int'(mem[rp2]), exp_m.pop_front());
            rp2++;
         end
         if (Push) begin
            pushes++;
            mem[wp] = din;
            exp_p.push_back(int'(din));
            exp_m.push_back(int'(din));
            wp++;
            din++;
         end
         if (done) dones++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rdy(input int pm, input int mm);
      hs.outp_ready = (pm == 2) ? 1'($urandom_range(0, 1)) : (pm == 1);
      hs.outm_ready = (mm == 2) ? 1'($urandom_range(0, 1)) : (mm == 1);
   endtask

   task automatic clr_cnt();
      pushes = 0; pops_p = 0; pops_m = 0; dones = 0;
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (dones == 0 && t < 600) begin step(); t++; end
      if (dones == 0) chk({nm, "_done_timeout"}, 0, 1);
   endtask

   // pm/mm: 0 = ready low, 1 = ready high, 2 = random (also randomises in_valid)
   typedef struct {
      int len; int pm; int mm; int hold;
      int h_push; int h_p; int h_m; bit full;
   } vec_t;

   task automatic run_frame(input vec_t v);
      clr_cnt();
      hs.in_valid = 1'b1;
      set_rdy(v.pm, v.mm);
      start = 1'b1;
      cfg_len = LW'(v.len);
      step();
      start = 1'b0;
      if (v.len == 0) begin
         chk("zero_done_next_cycle", int'(done), 1);
         chk("zero_busy", int'(busy), 0);
      end else begin
         chk("in_ready_after_start", int'(hs.in_ready), 1);
         chk("busy_after_start", int'(busy), 1);
      end
      for (int i = 0; i < v.hold; i++) begin
         set_rdy(v.pm, v.mm);
         if (v.pm == 2) hs.in_valid = 1'($urandom_range(0, 1));
         step();
      end
      if (v.h_push >= 0) chk("hold_pushes", pushes, v.h_push);
      if (v.h_p >= 0)    chk("hold_pops_p", pops_p, v.h_p);
      if (v.h_m >= 0)    chk("hold_pops_m", pops_m, v.h_m);
      if (v.full)        chk("full_in_ready", int'(hs.in_ready), 0);
      hs.in_valid = 1'b1;
      set_rdy(1, 1);
      wait_done("frame");
      chk("busy_after_done", int'(busy), 0);
      chk("done_single_cycle", int'(done), 0);
      step(); step();
      chk("frame_pushes", pushes, v.len);
      chk("frame_pops_p", pops_p, v.len);
      chk("frame_pops_m", pops_m, v.len);
      chk("frame_done_pulses", dones, 1);
      chk("scoreboard_empty", exp_p.size() + exp_m.size(), 0);
   endtask

   vec_t vt[7];

   initial begin
      vt[0] = '{4,  1, 1, 0,  -1, -1, -1, 1'b0};  // basic
      vt[1] = '{20, 0, 0, 40, 16, 0,  0,  1'b1};  // full stall
      vt[2] = '{20, 1, 0, 40, 16, 16, 0,  1'b1};  // lagging M reader
      vt[3] = '{0,  1, 1, 0,  -1, -1, -1, 1'b0};  // zero length
      vt[4] = '{1,  1, 1, 0,  -1, -1, -1, 1'b0};  // single word
      vt[5] = '{37, 2, 2, 60, -1, -1, -1, 1'b0};  // random, wraps twice
      vt[6] = '{50, 2, 1, 80, -1, -1, -1, 1'b0};  // random P, free M

      hs.in_valid = 1'b1;
      hs.outp_ready = 1'b1;
      hs.outm_ready = 1'b1;
      clr_cnt();
      step(); step();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_in_ready", int'(hs.in_ready), 0);
      chk("rst_outp_valid", int'(hs.outp_valid), 0);
      chk("rst_outm_valid", int'(hs.outm_valid), 0);
      chk("rst_strobes", int'({Push, Pop1, Pop2}), 0);
      aclr = 1'b1;
      step();

      for (int k = 0; k < 7; k++) run_frame(vt[k]);

      // start while busy is ignored and cfg_len is not resampled
      clr_cnt();
      start = 1'b1; cfg_len = 16'd5;
      step();
      start = 1'b0;
      step(); step();
      start = 1'b1; cfg_len = 16'd9;
      step();
      start = 1'b0;
      wait_done("busy_start");
      step(); step();
      chk("busy_start_pushes", pushes, 5);
      chk("busy_start_pops_p", pops_p, 5);
      chk("busy_start_pops_m", pops_m, 5);
      chk("busy_start_dones", dones, 1);

      // reset asserted while the 7th push is on the strobe
      begin
         int t = 0;
         clr_cnt();
         start = 1'b1; cfg_len = 16'd20;
         step();
         start = 1'b0;
         while (pushes < 6 && t < 100) begin step(); t++; end
         chk("pre_reset_pushes", pushes, 6);
         chk("pre_reset_push_strobe", int'(Push), 1);
         aclr = 1'b0;
         #1;
         chk("mid_rst_outputs",
             int'({busy, done, hs.in_ready, hs.outp_valid, hs.outm_valid, Push, Pop1, Pop2}), 0);
         step();
         aclr = 1'b1;
         step();
         run_frame('{3, 1, 1, 0, -1, -1, -1, 1'b0});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
